// File: rtl/hdmi_mode_ctrl.sv
// Purpose: debounces the user key and steps the HDMI test-pattern index, applying each change only at a frame start.
// Latency: key edge -> PENDING_O after 2 sync + DEBOUNCE_CYCLES + 1 cycles; MODE_O updates the cycle after the VS leading edge.
// Backpressure: none; at most one request is held pending and later presses are dropped. Optional auto-advance: HDMI_MODE_AUTO_EN.
module hdmi_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NUM_MODES       = 4,
    parameter int VS_POL          = 1,
    parameter int AUTO_FRAMES     = 300
) (
    input  logic       PXLCLK_I,
    input  logic       RST_N,
    input  logic       KEY_I,
    input  logic       VS_I,
    output logic [1:0] MODE_O,
    output logic [3:0] LED_O,
    output logic       MODE_CHG_O,
    output logic       PENDING_O
);

    localparam int         DEB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam logic [1:0] MODE_LAST = 2'(NUM_MODES - 1);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_PEND   = 1'b1;

    // Out-of-range parameters stop elaboration instead of building a broken controller.
    generate
        if (DEBOUNCE_CYCLES < 2 || NUM_MODES < 2 || NUM_MODES > 4 || AUTO_FRAMES < 1) begin : g_bad_param
            $error("hdmi_mode_ctrl: illegal parameter value");
        end
    endgenerate

    logic             sync1_q, key_s;
    logic             key_stb_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             press_q;
    logic             deb_hit;
    logic             vs_act, vs_d_q, frame_start;
    logic             req;
    logic [0:0]       state_q;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       led_q;
    logic             chg_q;

    // Two-flop synchronizer; both flops idle high (key released).
    always_ff @(posedge PXLCLK_I) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            key_s   <= 1'b1;
        end else begin
            sync1_q <= KEY_I;
            key_s   <= sync1_q;
        end
    end

    // The synchronized level must differ for DEBOUNCE_CYCLES cycles in a row before it is accepted.
    assign deb_hit = (key_s != key_stb_q) && (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));

    // Debounce counter, stable level, and a one-cycle press pulse on the accepted 1->0 transition.
    always_ff @(posedge PXLCLK_I) begin
        if (!RST_N) begin
            deb_cnt_q <= '0;
            key_stb_q <= 1'b1;
            press_q   <= 1'b0;
        end else begin
            press_q <= deb_hit && !key_s;
            if (key_s == key_stb_q || deb_hit) begin
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            if (deb_hit) begin
                key_stb_q <= key_s;
            end
        end
    end

    // VS is normalised to active-high so the frame-start detector is polarity independent.
    assign vs_act      = (VS_POL != 0) ? VS_I : ~VS_I;
    assign frame_start = vs_act && !vs_d_q;

    // One-cycle delayed VS used for leading-edge detection.
    always_ff @(posedge PXLCLK_I) begin
        if (!RST_N) begin
            vs_d_q <= 1'b0;
        end else begin
            vs_d_q <= vs_act;
        end
    end

`ifdef HDMI_MODE_AUTO_EN
    localparam int FRM_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;

    logic [FRM_W-1:0] frm_cnt_q;
    logic             auto_req;

    // A key press in the same cycle takes precedence so only one advance is queued.
    assign auto_req = frame_start && (frm_cnt_q == FRM_W'(AUTO_FRAMES - 1))
                      && (state_q == ST_IDLE) && !press_q;
    assign req      = press_q || auto_req;

    // Frame counter: counts frame starts, holds at its terminal value while a request is pending.
    always_ff @(posedge PXLCLK_I) begin
        if (!RST_N) begin
            frm_cnt_q <= '0;
        end else if (press_q || auto_req) begin
            frm_cnt_q <= '0;
        end else if (frame_start && frm_cnt_q != FRM_W'(AUTO_FRAMES - 1)) begin
            frm_cnt_q <= frm_cnt_q + 1'b1;
        end
    end
`else
    assign req = press_q;
`endif

    assign mode_d = (mode_q == MODE_LAST) ? 2'd0 : mode_q + 2'd1;

    // Request FSM; the mode and its LED image are registered together at the frame start.
    // A request raised in the frame-start cycle itself waits for the next frame.
    always_ff @(posedge PXLCLK_I) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            mode_q  <= 2'd0;
            led_q   <= 4'b0001;
            chg_q   <= 1'b0;
        end else begin
            chg_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= ST_PEND;
                    end
                end
                default: begin
                    if (frame_start) begin
                        state_q <= ST_IDLE;
                        mode_q  <= mode_d;
                        led_q   <= 4'b0001 << mode_d;
                        chg_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign MODE_O     = mode_q;
    assign LED_O      = led_q;
    assign MODE_CHG_O = chg_q;
    assign PENDING_O  = (state_q == ST_PEND);

endmodule

// File: tb/tb_hdmi_mode_ctrl.sv
// Purpose: directed self-checking bench for hdmi_mode_ctrl with a short debounce window.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives the key and VS directly.
module tb_hdmi_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic       vs;
    logic [1:0] mode;
    logic [3:0] led;
    logic       mode_chg;
    logic       pending;

    int passed = 0;
    int total  = 0;

    hdmi_mode_ctrl #(
        .DEBOUNCE_CYCLES(16),
        .NUM_MODES      (4),
        .VS_POL         (1),
        .AUTO_FRAMES    (3)
    ) dut (
        .PXLCLK_I  (clk),
        .RST_N     (rst_n),
        .KEY_I     (key),
        .VS_I      (vs),
        .MODE_O    (mode),
        .LED_O     (led),
        .MODE_CHG_O(mode_chg),
        .PENDING_O (pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input int m, input int l, input int c, input int p);
        chk({tag, ".mode"},    32'(mode),     32'(m));
        chk({tag, ".led"},     32'(led),      32'(l));
        chk({tag, ".chg"},     32'(mode_chg), 32'(c));
        chk({tag, ".pending"}, 32'(pending),  32'(p));
    endtask

    // Debounced press from IDLE: PENDING_O must rise exactly 19 edges after the key falls.
    task automatic press(input string tag);
        int n;
        key = 1'b0;
        n = 0;
        while (!pending && n < 40) begin
            tick(1);
            n++;
        end
        chk({tag, ".latency"}, 32'(n), 32'd19);
        tick(40 - n);
        key = 1'b1;
        tick(20);
    endtask

    // Full-length press with no latency expectation (used while already pending).
    task automatic press_nowait();
        key = 1'b0;
        tick(40);
        key = 1'b1;
        tick(20);
    endtask

    // Frame that must apply a pending request.
    task automatic frame_adv(input string tag, input int m);
        vs = 1'b1;
        tick(1);
        chk_state({tag, ".apply"}, m, 1 << m, 1, 0);
        tick(1);
        chk({tag, ".chg_one_cycle"}, 32'(mode_chg), 32'd0);
        vs = 1'b0;
        tick(2);
    endtask

    // Frame with nothing pending: no change allowed.
    task automatic frame_none(input string tag, input int m);
        vs = 1'b1;
        tick(1);
        chk({tag, ".chg"},  32'(mode_chg), 32'd0);
        chk({tag, ".mode"}, 32'(mode),     32'(m));
        vs = 1'b0;
        tick(2);
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 1'b1;
        vs    = 1'b0;
        tick(3);
        chk_state("in_reset", 0, 1, 0, 0);
        rst_n = 1'b1;
        tick(100);
        chk_state("idle100", 0, 1, 0, 0);

        // Short glitch is filtered out.
        key = 1'b0;
        tick(10);
        key = 1'b1;
        tick(30);
        chk_state("glitch", 0, 1, 0, 0);

        // First press; VS held inactive keeps the request pending.
        press("press1");
        tick(50);
        chk_state("vs_stuck", 0, 1, 0, 1);
        frame_adv("adv1", 1);

        // Remaining presses of the 1,2,3,0 sequence, wrapping back to LED 0001.
        press("press2");
        frame_adv("adv2", 2);
        press("press3");
        frame_adv("adv3", 3);
        press("press4");
        frame_adv("adv_wrap", 0);

        // Two presses within one frame give a single advance.
        press("dbl_a");
        press_nowait();
        chk("dbl_b.still_pending", 32'(pending), 32'd1);
        frame_adv("dbl_adv", 1);
        frame_none("dbl_no_second", 1);

        // Press accepted in the same cycle as the VS leading edge waits a frame.
        key = 1'b0;
        tick(18);
        vs = 1'b1;
        tick(1);
        chk_state("coinc_idle", 1, 2, 0, 1);
        tick(1);
        vs = 1'b0;
        tick(20);
        key = 1'b1;
        tick(20);
        chk_state("coinc_wait", 1, 2, 0, 1);
        frame_adv("coinc_adv", 2);

        // Reset with a request pending at mode 2.
        press("pre_rst");
        chk_state("pre_rst_state", 2, 4, 0, 1);
        rst_n = 1'b0;
        tick(1);
        chk_state("rst_mid", 0, 1, 0, 0);
        rst_n = 1'b1;
        tick(2);
        frame_none("post_rst_frame", 0);

        // Press coinciding with frame start while pending: apply, drop the press.
        press("pend_a");
        key = 1'b0;
        tick(18);
        vs = 1'b1;
        tick(1);
        chk_state("pend_coinc", 1, 2, 1, 0);
        vs = 1'b0;
        tick(1);
        chk_state("pend_coinc_next", 1, 2, 0, 0);
        tick(20);
        key = 1'b1;
        tick(20);
        frame_none("pend_coinc_dropped", 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
